// File: rtl/varredura_displays.sv
// varredura_displays -- time-multiplexed scan controller for NUM_DIG
// common-anode 7-segment displays that share one decodificador_7_seg.
//
// Each digit owns a slot of DIV_TICK clock cycles. A slot opens with
// APAGA_CICLOS dark cycles while digito/ponto already carry the slot's
// nibble. The decoder therefore settles before the anode turns on, which
// prevents ghosting. The shadow registers (sv, sp, sh) load once per frame,
// on the last cycle of the last slot, so a frame never shows a mix of old
// and new values.
//
// Optional build macro: SUPRIME_ZEROS_EN
//   When it is defined, leading zeros are suppressed. The check uses the
//   shadow registers. Starting from the leftmost digit, each digit whose
//   nibble is zero and whose point is clear stays dark. Suppression stops
//   at the first digit that is nonzero or has its point set. Digit 0 is
//   always shown.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   valores     nibble per digit; digit i = valores[4i+3:4i], digit 0 rightmost
//   pontos      decimal point request per digit (1 = lit)
//   habilita    per-digit enable (0 = digit kept dark, slot still consumed)
//   digito      nibble for the shared decoder
//   ponto       decimal point to the decoder, active-low
//   anodos      anode enables, active-low, at most one low at a time
//   fim_quadro  one-cycle pulse on the last cycle of the last slot
module varredura_displays #(
  parameter int NUM_DIG      = 4,
  parameter int DIV_TICK     = 50000,
  parameter int APAGA_CICLOS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NUM_DIG-1:0] valores,
  input  logic [NUM_DIG-1:0]   pontos,
  input  logic [NUM_DIG-1:0]   habilita,
  output logic [3:0]           digito,
  output logic                 ponto,
  output logic [NUM_DIG-1:0]   anodos,
  output logic                 fim_quadro
);

  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;

  localparam logic [CW-1:0] ULTIMO_CONT = CW'(DIV_TICK - 1);
  localparam logic [CW-1:0] FIM_APAGA   = CW'(APAGA_CICLOS - 1);
  localparam logic [IW-1:0] ULTIMO_IDX  = IW'(NUM_DIG - 1);

  typedef enum logic {APAGA, EXIBE} estado_t;

  estado_t              estado;
  logic [CW-1:0]        contador;
  logic [IW-1:0]        indice;
  logic [4*NUM_DIG-1:0] sv;
  logic [NUM_DIG-1:0]   sp;
  logic [NUM_DIG-1:0]   sh;

  logic                 fim_slot;
  logic                 fim_frame;
  logic [3:0]           dig_atual;
  logic                 mostra;
  logic [NUM_DIG-1:0]   suprime;

`ifdef SUPRIME_ZEROS_EN
  // Running AND from the leftmost digit down. It stays set only while every
  // digit seen so far is a zero without a point. Digit 0 is not included.
  logic zeros;
  always_comb begin
    suprime = '0;
    zeros   = 1'b1;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      zeros      = zeros & (sv[4*i +: 4] == 4'd0) & ~sp[i];
      suprime[i] = zeros;
    end
  end
`else
  assign suprime = '0;
`endif

  always_comb begin
    fim_slot  = (contador == ULTIMO_CONT);
    fim_frame = fim_slot && (indice == ULTIMO_IDX);
    dig_atual = sv[int'(indice)*4 +: 4];
    mostra    = sh[indice] & ~suprime[indice];
  end

  // Outputs register the view of the current (contador, indice). The value
  // shown after an edge therefore belongs to the cycle the counters held
  // when that edge arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      contador   <= '0;
      indice     <= '0;
      estado     <= APAGA;
      anodos     <= '1;
      digito     <= 4'd0;
      ponto      <= 1'b1;
      fim_quadro <= 1'b0;
      sv         <= valores;
      sp         <= pontos;
      sh         <= habilita;
    end else begin
      digito     <= dig_atual;
      ponto      <= ~(sp[indice] & sh[indice]);
      fim_quadro <= fim_frame;

      // estado tracks the phase of the current contador value. It drives
      // the anodes, so a slot wrap can never leave two digits lit.
      anodos <= '1;
      if (estado == EXIBE) begin
        anodos[indice] <= ~mostra;
      end

      case (estado)
        APAGA:   if (contador == FIM_APAGA) estado <= EXIBE;
        EXIBE:   if (fim_slot)              estado <= APAGA;
        default:                            estado <= APAGA;
      endcase

      if (fim_slot) begin
        contador <= '0;
        indice   <= (indice == ULTIMO_IDX) ? '0 : indice + 1'b1;
      end else begin
        contador <= contador + 1'b1;
      end

      if (fim_frame) begin
        sv <= valores;
        sp <= pontos;
        sh <= habilita;
      end
    end
  end

endmodule

// File: doc/varredura_displays.md
Name: varredura_displays

Overview:
- Time-multiplexed scan controller for a bank of NUM_DIG common-anode 7-segment displays.
- All digits share one decodificador_7_seg instance. This block drives the decoder's 4-bit input and dp bit, and drives one active-low anode enable per digit.
- Contains a slot prescaler, a blank/show state machine for anti-ghosting, and a shadow register that loads once per frame so digits never tear mid-frame.

Parameters:
- NUM_DIG, 4, number of digits scanned (2..8)
- DIV_TICK, 50000, clock cycles per digit slot (>= APAGA_CICLOS+2)
- APAGA_CICLOS, 16, blanking cycles at the start of each slot (>= 1)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous reset, active-high
- valores  input  4*NUM_DIG  nibble per digit; digit i = valores[4i+3:4i]; digit 0 is rightmost
- pontos  input  NUM_DIG  decimal point request per digit, 1 = lit
- habilita  input  NUM_DIG  per-digit enable; 0 = digit kept dark
- digito  output  4  to decoder entrada
- ponto  output  1  to decoder dp; active-low, 0 = lit, matching segment polarity
- anodos  output  NUM_DIG  anode enables, active-low
- fim_quadro  output  1  one-cycle pulse on the last cycle of the last slot

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - anodos = all 1
  - digito = 0
  - ponto = 1
  - fim_quadro = 0
  - indice = 0, contador = 0, estado = APAGA
- While rst = 1, the shadow registers (sv, sp, sh) sample valores, pontos and habilita every cycle.
- Prescaler: contador counts 0..DIV_TICK-1 and wraps to 0. At the wrap, indice advances. indice wraps from NUM_DIG-1 to 0.
- State machine:
  - APAGA: active while contador < APAGA_CICLOS. anodos = all 1. digito and ponto are already updated to slot indice, so the decoder settles while dark.
  - EXIBE: active while contador >= APAGA_CICLOS. anodos[indice] = ~sh[indice]; all other anodos = 1.
  - EXIBE -> APAGA happens at the slot wrap.
- Output values within slot indice:
  - digito = sv[indice]
  - ponto = ~(sp[indice] & sh[indice])
- Disabled digit: its slot is still consumed (constant duty cycle across digits); its anode stays 1 for the whole slot.
- Frame boundary:
  - fim_quadro = 1 when indice = NUM_DIG-1 and contador = DIV_TICK-1.
  - Shadow registers load valores, pontos and habilita on that same edge; the new values are visible from slot 0 of the next frame.
  - Input changes mid-frame have no effect until that load.
- Latency: after rst falls, slot 0 shows from cycle APAGA_CICLOS. The first fim_quadro occurs at cycle NUM_DIG*DIV_TICK-1.
- Reset asserted mid-slot: next cycle all anodos = 1 and indice = 0. No partial slot resumes.
- No more than one anode is ever low in any cycle, including across slot transitions.

Optional Feature:
- Macro: SUPRIME_ZEROS_EN.
- Defined: leading-zero suppression, evaluated on the shadow registers.
  - Scanning from digit NUM_DIG-1 down to 1, each digit with sv = 0 and sp = 0 is blanked (anode held 1) until the first digit that is nonzero or has its point set.
  - Digit 0 is never suppressed.
- Undefined: all enabled digits are shown, zeros included.

Test Plan:
- Sim parameters for all tests: NUM_DIG=4, DIV_TICK=8, APAGA_CICLOS=2.
- Reset/timing: release rst, valores=16'h4321, habilita=4'hF -> cycles 0-1 anodos=1111, digito=1; cycles 2-7 anodos=1110; cycle 8 digito=2; cycles 10-15 anodos=1101; fim_quadro=1 only at cycle 31; cycle 32 anodos=1111 with digito=1.
- Tear-free update: change valores to 16'h8765 at cycle 12 -> slots 2 and 3 still show 3 and 4; digito=5 from cycle 32.
- Enable and point: habilita=4'b1011, pontos=4'b0110 -> slot 2 anodos stay 1111 for all 8 cycles; slot 1 ponto=0; slot 2 ponto=1.
- Mid-slot reset: assert rst at cycle 21 for 1 cycle -> cycle 22 anodos=1111, indice=0; next fim_quadro exactly 32 cycles after rst falls.
- SUPRIME_ZEROS_EN: valores=16'h0040, pontos=0 -> digits 3 and 2 dark, digits 1 and 0 shown (4, 0). Macro undefined -> all four shown.
